// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the Sobol front end: datapath width, the tag that
// travels with every generator request, and the sequencer state encoding.
package fpga_cfg_pkg;

  localparam int unsigned FP_WIDTH    = 32;
  // Tag dimension field is sized for up to 256 time steps; sequencers truncate.
  localparam int unsigned SOBOL_DIM_W = 8;

  typedef struct packed {
    logic [FP_WIDTH-1:0]    idx;
    logic [SOBOL_DIM_W-1:0] dim;
    logic                   last;
  } sobol_tag_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sobol_seq_state_e;

endpackage

// File: rtl/sobol_req_seq_if.sv
// Generator request/response and downstream sample stream of the sequencer.
interface sobol_req_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIM_W = 6
);
  logic             req_valid;
  logic [WIDTH-1:0] req_idx;
  logic [DIM_W-1:0] req_dim;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_idx;
  logic [DIM_W-1:0] out_dim;
  logic             out_last;

  // Sequencer side.
  modport master (
    output req_valid, req_idx, req_dim,
    input  rsp_valid, rsp_data,
    output out_valid, out_data, out_idx, out_dim, out_last,
    input  out_ready
  );

  // Generator model and downstream consumer side.
  modport slave (
    input  req_valid, req_idx, req_dim,
    output rsp_valid, rsp_data,
    input  out_valid, out_data, out_idx, out_dim, out_last,
    output out_ready
  );
endinterface

// File: rtl/sobol_out_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. Depth must be a power of two.
module sobol_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_en, pop_en;

  // Pointer/count update; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop_en   = pop_i && (cnt_q != '0);
    push_en  = push_i && ((cnt_q != CntW'(Depth)) || pop_en);
    wr_ptr_d = wr_ptr_q + PtrW'(push_en);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
    cnt_d    = cnt_q + CntW'(push_en) - CntW'(pop_en);
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/sobol_req_seq.sv
// Sobol request sequencer: sweeps (idx, dim) path-major into the point generator,
// tags the fixed-latency responses and streams them out through a credit-guarded FIFO.
// Optional build macro SOBOL_SEQ_DIGITAL_SHIFT_EN: XOR samples with the start-time mask.
module sobol_req_seq
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WIDTH      = FP_WIDTH,
  parameter int unsigned M          = 50,
  parameter int unsigned N_PATHS    = 1024,
  parameter int unsigned IDX_BASE   = 1,
  parameter int unsigned GEN_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] shift_mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  sobol_req_seq_if.master  bus
);
  localparam int unsigned DIM_W = $clog2(M);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned TOTAL = N_PATHS * M;
  localparam int unsigned TOT_W = $clog2(TOTAL + 1);
  localparam int unsigned FW    = $bits(sobol_tag_t) + WIDTH;

  sobol_seq_state_e state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [DIM_W-1:0] dim_q, dim_d;
  logic [TOT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             req_valid_q, req_valid_d, req_last_q, req_last_d;
  logic [WIDTH-1:0] req_idx_q, req_idx_d;
  logic [DIM_W-1:0] req_dim_q, req_dim_d;
  logic             err_q, err_d;

  logic [GEN_LAT-1:0] pipe_vld_q;
  sobol_tag_t         pipe_tag_q [GEN_LAT];
  sobol_tag_t         req_tag, out_tag;
  logic               head_v, push, pop;
  logic [FW-1:0]      fifo_wdata, fifo_rdata;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [OCC_W-1:0]   occ;
  logic [WIDTH-1:0]   sample;

  assign head_v = pipe_vld_q[GEN_LAT-1];
  assign push   = bus.rsp_valid && head_v;
  assign pop    = !fifo_empty && bus.out_ready;
  // Slots already committed next cycle: queued samples plus requests not yet answered.
  assign occ    = OCC_W'(fifo_cnt) + OCC_W'(inflight_q) - OCC_W'(pop);

  // Tag for the request currently on the generator interface.
  always_comb begin
    req_tag      = '0;
    req_tag.idx  = FP_WIDTH'(req_idx_q);
    req_tag.dim  = SOBOL_DIM_W'(req_dim_q);
    req_tag.last = req_last_q;
  end

  // Sequencer FSM, request issue and in-flight accounting.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dim_d       = dim_q;
    issue_cnt_d = issue_cnt_q;
    req_valid_d = 1'b0;
    req_idx_d   = '0;
    req_dim_d   = '0;
    req_last_d  = 1'b0;
    err_d       = err_q | (bus.rsp_valid & ~head_v);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          idx_d       = WIDTH'(IDX_BASE);
          dim_d       = '0;
          issue_cnt_d = '0;
        end
      end
      StRun: begin
        if ((issue_cnt_q != TOT_W'(TOTAL)) && (occ < OCC_W'(FIFO_DEPTH))) begin
          req_valid_d = 1'b1;
          req_idx_d   = idx_q;
          req_dim_d   = dim_q;
          req_last_d  = (issue_cnt_q == TOT_W'(TOTAL - 1));
          issue_cnt_d = issue_cnt_q + TOT_W'(1);
          if (dim_q == DIM_W'(M - 1)) begin
            dim_d = '0;
            idx_d = idx_q + WIDTH'(1);
          end else begin
            dim_d = dim_q + DIM_W'(1);
          end
        end
        if (req_valid_q && req_last_q) state_d = StDrain;
      end
      StDrain: begin
        // Leave once the final queued beat is transferring and nothing is in flight.
        if ((inflight_q == '0) && (fifo_empty || ((fifo_cnt == CNT_W'(1)) && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    inflight_d = inflight_q + CNT_W'(req_valid_d) - CNT_W'(head_v);
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dim_q       <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= '0;
      req_valid_q <= 1'b0;
      req_idx_q   <= '0;
      req_dim_q   <= '0;
      req_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dim_q       <= dim_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
      req_dim_q   <= req_dim_d;
      req_last_q  <= req_last_d;
      err_q       <= err_d;
    end
  end

  // Tag pipe: head lines up with the generator's valid_out GEN_LAT cycles after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < GEN_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= req_valid_q;
      pipe_tag_q[0] <= req_tag;
      for (int i = 1; i < GEN_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign fifo_wdata = {pipe_tag_q[GEN_LAT-1], bus.rsp_data};

  sobol_out_fifo #(
    .Width (FW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_tag = sobol_tag_t'(fifo_rdata[FW-1:WIDTH]);

`ifdef SOBOL_SEQ_DIGITAL_SHIFT_EN
  logic [WIDTH-1:0] shift_mask_q;

  // Mask is frozen for the whole run at the accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_mask_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      shift_mask_q <= shift_mask_i;
    end
  end

  assign sample = fifo_rdata[WIDTH-1:0] ^ shift_mask_q;
`else
  logic unused_shift_mask;
  assign unused_shift_mask = ^shift_mask_i;
  assign sample            = fifo_rdata[WIDTH-1:0];
`endif

  assign bus.req_valid = req_valid_q;
  assign bus.req_idx   = req_idx_q;
  assign bus.req_dim   = req_dim_q;
  // Stream fields are forced to zero while nothing is queued.
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : sample;
  assign bus.out_idx   = fifo_empty ? '0 : WIDTH'(out_tag.idx);
  assign bus.out_dim   = fifo_empty ? '0 : DIM_W'(out_tag.dim);
  assign bus.out_last  = !fifo_empty && out_tag.last;

  assign busy_o = (state_q == StRun) || (state_q == StDrain);
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;

endmodule

// File: doc/sobol_req_seq.md
Name: sobol_req_seq

Overview:
- Initiator/sequencer for the Sobol point generator. On `start` it sweeps path index × time-step dimension, issuing `(idx, dim)` requests on the generator's `valid/idx/dim` interface.
- Captures the generator's fixed-latency responses into a credit-protected output FIFO and presents tagged samples downstream on a ready/valid stream.
- Sits between the run controller and the path simulator (Box-Muller / GBM stage).

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH, width of idx and sobol data.
- M, 50, dimensions (time steps) per path.
- N_PATHS, 1024, paths per run.
- IDX_BASE, 1, first Sobol index issued (skips the all-zero point).
- GEN_LAT, 1, generator valid_in→valid_out latency in cycles, ≥1.
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥ GEN_LAT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request; honoured only in IDLE
- shift_mask  in  WIDTH  digital-shift mask, latched on accepted start (used only with the optional feature)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when a run completes
- err  out  1  sticky: a response arrived with no request outstanding; cleared only by reset
- req_valid  out  1  to generator valid_in
- req_idx  out  WIDTH  to generator idx_in
- req_dim  out  $clog2(M)  to generator dim_in
- rsp_valid  in  1  from generator valid_out
- rsp_data  in  WIDTH  from generator sobol_out
- out_valid  out  1  downstream valid
- out_ready  in  1  downstream ready
- out_data  out  WIDTH  sample value
- out_idx  out  WIDTH  path index of sample
- out_dim  out  $clog2(M)  dimension of sample
- out_last  out  1  last sample of the run (idx = IDX_BASE+N_PATHS-1, dim = M-1)

Behaviour:
- Reset values: every output 0, FSM in IDLE, counters 0, FIFO empty, `err` 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`. Loads `idx=IDX_BASE`, `dim=0` and latches `shift_mask`.
  - RUN→DRAIN in the cycle after the final request issues.
  - DRAIN→DONE when FIFO is empty, in-flight count is 0 and no output beat is pending.
  - DONE→IDLE unconditionally. `done`=1 only while in DONE.
  - `start` outside IDLE is ignored.
- Issue order is path-major: dim 0..M-1 for each idx, then idx+1. Dim wraps M-1→0 with an idx increment.
- Requests are registered outputs: `req_valid` is 1 in RUN when `credits>0`, and at most one request is issued per cycle.
  - `credits = FIFO_DEPTH - fifo_count - inflight`, evaluated each cycle including same-cycle pop and response.
  - The generator cannot stall, so this credit scheme guarantees FIFO never overflows.
- Tags: `{idx, dim, last}` enter a GEN_LAT-deep shift pipe aligned with `req_valid`. On `rsp_valid`, `rsp_data` plus the tag at the pipe head are pushed to the FIFO.
- `rsp_valid` with no valid tag sets `err`. The data is dropped, the FIFO is not written and `inflight` does not underflow.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Output is FIFO head, show-ahead. A beat transfers when `out_valid && out_ready`. While `out_ready`=0, `out_data`, `out_idx`, `out_dim` and `out_last` hold stable.
- Zero-bubble throughput: with `out_ready` held at 1, one sample per cycle after GEN_LAT+1 startup cycles.
- Total samples per run = N_PATHS·M. The counter is sized $clog2(N_PATHS·M+1).
- Reset mid-run aborts immediately to reset values. No `done` pulse is produced.

Optional Feature:
- Macro: `SOBOL_SEQ_DIGITAL_SHIFT_EN`.
- Defined: `out_data = fifo_data ^ shift_mask_q`, a Cranley-Patterson digital shift using the mask latched at start.
- Undefined: `out_data = fifo_data`. `shift_mask` is ignored and no mask register is built.

Decomposition:
- fpga_cfg_pkg holds:
  - FP_WIDTH.
  - typedef `sobol_tag_t`, a struct `{idx, dim, last}`.
  - enum `sobol_seq_state_e`.
- One sub-module: `sobol_out_fifo`, a parameterised synchronous FIFO with count output. The data word is `{tag, data}`.
- Counters, tag pipe and FSM stay in `sobol_req_seq`.

Test Plan:
- Basic run. Config: M=4, N_PATHS=3, IDX_BASE=1, GEN_LAT=1; the generator model returns `idx*16+dim`; `out_ready`=1.
  - Output: 12 beats, in order (1,0)=0x10, (1,1)=0x11 … (3,3)=0x33.
  - `out_last` is set only on (3,3). `done` pulses once, 1 cycle after the last beat. `busy` then drops.
- Backpressure. Same config; `out_ready` toggles 0/1 every 3 cycles.
  - No beat is lost or duplicated, and outputs hold stable while not ready.
  - `req_valid` stalls when FIFO plus in-flight equals 4. `err` stays 0.
- Latency sweep. GEN_LAT=3, FIFO_DEPTH=4, `out_ready`=0 for 20 cycles, then 1.
  - Exactly 4 requests are issued during the stall, then the full 12-beat run completes in order.
- Protocol error. Inject `rsp_valid`=1 while IDLE.
  - `err`=1 and stays 1; FIFO stays empty.
  - A subsequent start still completes a normal run with `err` held at 1.
- Reset mid-run. Assert `rst_n`=0 after 5 output beats.
  - All outputs are 0 and the FSM is in IDLE. No `done` is produced.
  - A new start restarts from (1,0).
- Digital shift (macro defined). `shift_mask`=0xFFFF_0000 at start, then changed mid-run.
  - Every `out_data = model ^ 0xFFFF_0000`, using the latched value.
  - With the macro undefined, output equals the model value.
